// File: rtl/jh_ext_sram_prefetch_fifo.sv
// Valid/ready FIFO over an external single-port SRAM with a register prefetch buffer on the output side.
// Write to out_valid takes MEM_RD_LATENCY+2 cycles through an empty FIFO; in_ready drops when full, on clear, or for one forced-read cycle.
module jh_ext_sram_prefetch_fifo #(
    parameter int DATA_WIDTH     = 8,
    parameter int FIFO_DEPTH     = 256,
    parameter int MEM_RD_LATENCY = 1,
    parameter int PREFETCH_DEPTH = 4,
    parameter int AF_THRESH      = FIFO_DEPTH - 4,
    parameter int AE_THRESH      = 4,
    parameter int MAX_WR_BURST   = 16
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          clear,
    input  logic [DATA_WIDTH-1:0]         in_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    output logic [DATA_WIDTH-1:0]         out_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH)-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0]         mem_din,
    output logic                          mem_wr_en,
    output logic                          mem_rd_en,
    input  logic [DATA_WIDTH-1:0]         mem_dout,
    output logic [$clog2(FIFO_DEPTH):0]   count,
    output logic                          almost_full,
    output logic                          almost_empty
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int PW = $clog2(PREFETCH_DEPTH);
    localparam int OW = PW + 2;
    localparam int SW = $clog2(MAX_WR_BURST + 2);
    localparam int L  = MEM_RD_LATENCY;

    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
    localparam logic [OW-1:0] PF_C    = OW'(PREFETCH_DEPTH);
    localparam logic [SW-1:0] BURST_C = SW'(MAX_WR_BURST);

    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_mem_cnt;
    logic [AW-1:0]         r_waddr;
    logic [AW-1:0]         r_raddr;
    logic [L-1:0]          r_stg;
    logic [SW-1:0]         r_streak;
    logic [DATA_WIDTH-1:0] r_pf [PREFETCH_DEPTH];
    logic [PW-1:0]         r_pf_wp;
    logic [PW-1:0]         r_pf_rp;
    logic [PW:0]           r_pf_cnt;

    logic [L-1:0]  w_stg_nxt;
    logic [OW-1:0] w_infl;
    logic [OW-1:0] w_pf_occ;
    logic          w_in_exec;
    logic          w_out_exec;
    logic          w_force_rd;
    logic          w_rd_ok;
    logic          w_rd;
    logic          w_push;
    logic          w_streak_inc;

    // Reads in flight reserve buffer slots so a returning word always has room.
    always_comb begin
        w_infl = '0;
        for (int i = 0; i < L; i++) begin
            w_infl = w_infl + OW'(r_stg[i]);
        end
    end

    always_comb begin
        w_stg_nxt    = '0;
        w_stg_nxt[0] = w_rd;
        for (int i = 1; i < L; i++) begin
            w_stg_nxt[i] = r_stg[i-1];
        end
    end

    assign w_pf_occ     = OW'(r_pf_cnt) + w_infl;
    assign w_force_rd   = (MAX_WR_BURST != 0) && (r_streak == BURST_C);
    assign in_ready     = (r_count < DEPTH_C) && !w_force_rd && !clear;
    assign w_in_exec    = in_valid && in_ready;
    assign out_valid    = (r_pf_cnt != '0) && !clear;
    assign w_out_exec   = out_valid && out_ready;
    assign w_rd_ok      = (r_mem_cnt != '0) && (w_pf_occ < PF_C);
    assign w_rd         = !w_in_exec && w_rd_ok && !clear;
    assign w_push       = r_stg[L-1] && !clear;
    assign w_streak_inc = w_in_exec && (r_pf_cnt == '0) && (r_mem_cnt != '0);

    // Strobes are gated by rstn so they drop the instant reset asserts.
    assign mem_wr_en    = w_in_exec && rstn;
    assign mem_rd_en    = w_rd && rstn;
    assign mem_addr     = w_in_exec ? r_waddr : r_raddr;
    assign mem_din      = in_data;
    assign out_data     = r_pf[r_pf_rp];
    assign count        = r_count;
    assign almost_full  = (r_count >= AF_C);
    assign almost_empty = (r_count <= AE_C);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count   <= '0;
            r_mem_cnt <= '0;
            r_waddr   <= '0;
            r_raddr   <= '0;
            r_stg     <= '0;
            r_streak  <= '0;
            r_pf_wp   <= '0;
            r_pf_rp   <= '0;
            r_pf_cnt  <= '0;
        end else if (clear) begin
            r_count   <= '0;
            r_mem_cnt <= '0;
            r_waddr   <= '0;
            r_raddr   <= '0;
            r_stg     <= '0;
            r_streak  <= '0;
            r_pf_wp   <= '0;
            r_pf_rp   <= '0;
            r_pf_cnt  <= '0;
        end else begin
            r_stg <= w_stg_nxt;

            if (w_in_exec && !w_out_exec) begin
                r_count <= r_count + CW'(1);
            end else if (!w_in_exec && w_out_exec) begin
                r_count <= r_count - CW'(1);
            end

            if (w_in_exec) begin
                r_waddr   <= r_waddr + AW'(1);
                r_mem_cnt <= r_mem_cnt + CW'(1);
            end else if (w_rd) begin
                r_raddr   <= r_raddr + AW'(1);
                r_mem_cnt <= r_mem_cnt - CW'(1);
            end

            // A forced-read cycle never writes, so the streak falls back to zero there.
            r_streak <= w_streak_inc ? r_streak + SW'(1) : '0;

            if (w_push) begin
                r_pf_wp <= r_pf_wp + PW'(1);
            end
            if (w_out_exec) begin
                r_pf_rp <= r_pf_rp + PW'(1);
            end
            if (w_push && !w_out_exec) begin
                r_pf_cnt <= r_pf_cnt + (PW+1)'(1);
            end else if (!w_push && w_out_exec) begin
                r_pf_cnt <= r_pf_cnt - (PW+1)'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pf[r_pf_wp] <= mem_dout;
        end
    end

endmodule
